vscale_hasti_arbiter: RTL and testbench

Two-master HASTI (AHB-Lite) arbiter that shares one HASTI slave, typically `vscale_hasti_sram`, between the core's instruction port (m0) and data port (m1). It multiplexes address phases with round-robin priority and tracks the data-phase owner to steer write data and responses. When a master loses arbitration in the same cycle its previous transfer completes, the block buffers that read data so no completed beat is lost.

---
 rtl/vscale_hasti_arbiter_if.sv | 42 ++++
 rtl/vscale_hasti_arbiter.sv | 102 ++++++++++
 tb/tb_vscale_hasti_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vscale_hasti_arbiter_if.sv
// Bus bundle between the two core-side HASTI masters, the arbiter and the shared slave.
// Master-side vectors are packed {m1, m0}.
interface vscale_hasti_arbiter_if;
   logic [63:0] m_haddr;
   logic [1:0]  m_hwrite;
   logic [5:0]  m_hsize;
   logic [5:0]  m_hburst;
   logic [1:0]  m_hmastlock;
   logic [7:0]  m_hprot;
   logic [3:0]  m_htrans;
   logic [63:0] m_hwdata;
   logic [63:0] m_hrdata;
   logic [1:0]  m_hready;
   logic [1:0]  m_hresp;

   logic [31:0] s_haddr;
   logic        s_hwrite;
   logic [2:0]  s_hsize;
   logic [2:0]  s_hburst;
   logic        s_hmastlock;
   logic [3:0]  s_hprot;
   logic [1:0]  s_htrans;
   logic [31:0] s_hwdata;
   logic [31:0] s_hrdata;
   logic        s_hready;
   logic        s_hresp;

   // slave: the arbiter's view; master: the masters plus the shared slave around it
   modport slave (
      input  m_haddr, m_hwrite, m_hsize, m_hburst, m_hmastlock, m_hprot, m_htrans, m_hwdata,
      output m_hrdata, m_hready, m_hresp,
      output s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot, s_htrans, s_hwdata,
      input  s_hrdata, s_hready, s_hresp
   );

   modport master (
      output m_haddr, m_hwrite, m_hsize, m_hburst, m_hmastlock, m_hprot, m_htrans, m_hwdata,
      input  m_hrdata, m_hready, m_hresp,
      input  s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot, s_htrans, s_hwdata,
      output s_hrdata, s_hready, s_hresp
   );
endinterface

// File: rtl/vscale_hasti_arbiter.sv
// Round-robin two-master HASTI arbiter with data-phase owner tracking and a per-master
// read-data hold for beats that complete while their master loses the next arbitration.
module vscale_hasti_arbiter (
   input logic                   hclk,
   input logic                   hresetn,
   vscale_hasti_arbiter_if.slave bus
);
   localparam logic [1:0] HTRANS_IDLE = 2'b00;
   localparam logic       HRESP_OKAY  = 1'b0;

   logic [1:0]       w_req;
   logic [1:0]       w_gnt;
   logic [1:0]       w_own;
   logic [1:0]       w_hready;
   logic [1:0]       w_hresp;
   logic [1:0]       w_hold_cap;
   logic [63:0]      w_hrdata;
   logic             w_gnt_any;
   logic             w_sel;

   logic             r_last_gnt;
   logic             r_dp_valid;
   logic             r_dp_owner;
   logic [1:0]       r_hold_valid;
   logic [1:0]       r_hold_resp;
   logic [1:0][31:0] r_hold_data;

   assign w_req = {bus.m_htrans[3], bus.m_htrans[1]};

   // Contention goes to whoever did not win last; reset forces every grant off.
   always_comb begin
      w_gnt = 2'b00;
      if (hresetn && bus.s_hready) begin
         if (&w_req) w_gnt = r_last_gnt ? 2'b01 : 2'b10;
         else        w_gnt = w_req;
      end
   end

   assign w_gnt_any = |w_gnt;
   assign w_sel     = w_gnt[1];

   assign bus.s_haddr     = w_sel ? bus.m_haddr[63:32]  : bus.m_haddr[31:0];
   assign bus.s_hwrite    = w_sel ? bus.m_hwrite[1]     : bus.m_hwrite[0];
   assign bus.s_hsize     = w_sel ? bus.m_hsize[5:3]    : bus.m_hsize[2:0];
   assign bus.s_hburst    = w_sel ? bus.m_hburst[5:3]   : bus.m_hburst[2:0];
   assign bus.s_hmastlock = w_sel ? bus.m_hmastlock[1]  : bus.m_hmastlock[0];
   assign bus.s_hprot     = w_sel ? bus.m_hprot[7:4]    : bus.m_hprot[3:0];
   assign bus.s_htrans    = !w_gnt_any ? HTRANS_IDLE :
                            (w_sel ? bus.m_htrans[3:2] : bus.m_htrans[1:0]);
   assign bus.s_hwdata    = r_dp_owner ? bus.m_hwdata[63:32] : bus.m_hwdata[31:0];

   assign w_own = !r_dp_valid ? 2'b00 : (r_dp_owner ? 2'b10 : 2'b01);

   always_comb begin
      w_hready   = 2'b11;
      w_hresp    = {2{HRESP_OKAY}};
      w_hrdata   = {2{bus.s_hrdata}};
      w_hold_cap = 2'b00;
      for (int i = 0; i < 2; i++) begin
         w_hold_cap[i] = bus.s_hready & w_own[i] & w_req[i] & ~w_gnt[i];
         if (hresetn)
            w_hready[i] = (~w_req[i] | w_gnt[i]) & (r_hold_valid[i] | ~w_own[i] | bus.s_hready);
         if (r_hold_valid[i]) begin
            w_hrdata[32*i +: 32] = r_hold_data[i];
            w_hresp[i]           = r_hold_resp[i];
         end else if (w_own[i]) begin
            w_hresp[i] = bus.s_hresp;
         end
      end
   end

   assign bus.m_hready = w_hready;
   assign bus.m_hresp  = w_hresp;
   assign bus.m_hrdata = w_hrdata;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_last_gnt   <= 1'b1;
         r_dp_valid   <= 1'b0;
         r_dp_owner   <= 1'b0;
         r_hold_valid <= 2'b00;
         r_hold_resp  <= 2'b00;
         r_hold_data  <= '0;
      end else begin
         if (w_gnt_any) r_last_gnt <= w_sel;
         if (bus.s_hready) begin
            r_dp_valid <= w_gnt_any;
            r_dp_owner <= w_sel;
         end
         // A captured beat is replayed on the cycle the master's next address is finally granted.
         for (int i = 0; i < 2; i++) begin
            if (w_hold_cap[i]) begin
               r_hold_valid[i] <= 1'b1;
               r_hold_data[i]  <= bus.s_hrdata;
               r_hold_resp[i]  <= bus.s_hresp;
            end else if (w_hready[i]) begin
               r_hold_valid[i] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Bench for vscale_hasti_arbiter: word-array slave model, directed scenarios and
// randomized two-master traffic scored against a transaction-level memory model.
module tb_vscale_hasti_arbiter;
   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] NONSEQ = 2'b10;

   logic hclk    = 1'b0;
   logic hresetn = 1'b0;
   int   total   = 0;
   int   bad     = 0;

   vscale_hasti_arbiter_if bus();

   vscale_hasti_arbiter dut (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (bus)
   );

   always #5 hclk = ~hclk;

   // ---------------- slave model ----------------
   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];
   logic        stall   = 1'b0;
   logic        sr_v, sr_w;
   logic [31:0] sr_a;
   logic [2:0]  sr_sz;
   logic        ld_en   = 1'b0;
   logic [7:0]  ld_idx  = 8'd0;
   logic [31:0] ld_data = 32'd0;

   function automatic logic [3:0] lanes(input logic [31:0] a, input logic [2:0] sz);
      case (sz)
         3'd0:    lanes = 4'b0001 << a[1:0];
         3'd1:    lanes = a[1] ? 4'b1100 : 4'b0011;
         default: lanes = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] ln);
      merge = old;
      for (int b = 0; b < 4; b++)
         if (ln[b]) merge[8*b +: 8] = wd[8*b +: 8];
   endfunction

   assign bus.s_hready = ~stall;
   assign bus.s_hresp  = 1'b0;
   assign bus.s_hrdata = (sr_v && !sr_w) ? mem[sr_a[9:2]] : 32'h0;

   always @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         sr_v <= 1'b0;
      end else if (bus.s_hready) begin
         sr_v  <= bus.s_htrans[1];
         sr_w  <= bus.s_hwrite;
         sr_a  <= bus.s_haddr;
         sr_sz <= bus.s_hsize;
      end
   end

   always @(posedge hclk) begin
      if (ld_en)
         mem[ld_idx] <= ld_data;
      else if (hresetn && bus.s_hready && sr_v && sr_w)
         mem[sr_a[9:2]] <= merge(mem[sr_a[9:2]], bus.s_hwdata, lanes(sr_a, sr_sz));
   end

   // ---------------- drive helpers ----------------
   task automatic drv(input int i, input logic [1:0] tr, input logic [31:0] a,
                      input logic w, input logic [2:0] sz);
      bus.m_htrans[2*i +: 2] = tr;
      bus.m_haddr[32*i +: 32] = a;
      bus.m_hwrite[i]        = w;
      bus.m_hsize[3*i +: 3]  = sz;
   endtask

   task automatic tick;
      @(posedge hclk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic ref_write(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] sz);
      ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], wd, lanes(a, sz));
   endtask

   task automatic do_reset;
      drv(0, IDLE, 32'h0, 1'b0, 3'd2);
      drv(1, IDLE, 32'h0, 1'b0, 3'd2);
      hresetn = 1'b0;
      tick;
      hresetn = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      drv(0, NONSEQ, 32'h10, 1'b0, 3'd2);
      drv(1, NONSEQ, 32'h210, 1'b0, 3'd2);
      settle;
      total++; if (bus.s_htrans !== IDLE) begin bad++; $display("FAIL rst_htrans got=%0h exp=0", bus.s_htrans); end
      total++; if (bus.m_hready !== 2'b11) begin bad++; $display("FAIL rst_hready got=%0b exp=11", bus.m_hready); end
      total++; if (bus.m_hresp !== 2'b00) begin bad++; $display("FAIL rst_hresp got=%0b exp=00", bus.m_hresp); end
      total++; if (bus.m_hrdata !== {2{bus.s_hrdata}}) begin bad++; $display("FAIL rst_hrdata got=%0h exp=%0h", bus.m_hrdata, {2{bus.s_hrdata}}); end
      do_reset;
      tick;
   endtask

   task automatic test_single_read;
      drv(0, NONSEQ, 32'h10, 1'b0, 3'd2);
      bus.m_hprot[3:0] = 4'h3;
      settle;
      total++; if (bus.s_htrans !== NONSEQ) begin bad++; $display("FAIL single_htrans got=%0h exp=2", bus.s_htrans); end
      total++; if (bus.s_haddr !== 32'h10) begin bad++; $display("FAIL single_haddr got=%0h exp=10", bus.s_haddr); end
      total++; if (bus.s_hprot !== 4'h3) begin bad++; $display("FAIL single_hprot got=%0h exp=3", bus.s_hprot); end
      total++; if (bus.m_hready[0] !== 1'b1) begin bad++; $display("FAIL single_hready0 got=%0b exp=1", bus.m_hready[0]); end
      tick;
      drv(0, IDLE, 32'h10, 1'b0, 3'd2);
      bus.m_hprot[3:0] = 4'h0;
      settle;
      total++; if (bus.m_hready[0] !== 1'b1) begin bad++; $display("FAIL single_dp_hready got=%0b exp=1", bus.m_hready[0]); end
      total++; if (bus.m_hrdata[31:0] !== ref_mem[4]) begin bad++; $display("FAIL single_rdata got=%0h exp=%0h", bus.m_hrdata[31:0], ref_mem[4]); end
      tick;
   endtask

   task automatic test_contention;
      logic [31:0] a  [2];
      logic [31:0] pe [2];
      logic        pv [2];
      a[0] = 32'h100; a[1] = 32'h200; pv[0] = 1'b0; pv[1] = 1'b0;
      pe[0] = 32'h0;  pe[1] = 32'h0;
      do_reset;
      for (int k = 0; k < 8; k++) begin
         drv(0, NONSEQ, a[0], 1'b0, 3'd2);
         drv(1, NONSEQ, a[1], 1'b0, 3'd2);
         settle;
         total++; if (bus.m_hready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL cont_hready k=%0d got=%0b exp_winner=m%0d", k, bus.m_hready, k % 2); end
         total++; if (bus.s_haddr !== a[k % 2]) begin bad++; $display("FAIL cont_haddr k=%0d got=%0h exp=%0h", k, bus.s_haddr, a[k % 2]); end
         for (int i = 0; i < 2; i++) begin
            if (bus.m_hready[i]) begin
               if (pv[i]) begin
                  total++; if (bus.m_hrdata[32*i +: 32] !== pe[i]) begin bad++; $display("FAIL cont_rdata m%0d k=%0d got=%0h exp=%0h", i, k, bus.m_hrdata[32*i +: 32], pe[i]); end
               end
               pv[i] = 1'b1;
               pe[i] = ref_mem[a[i][9:2]];
               a[i]  = a[i] + 32'd4;
            end
         end
         tick;
      end
      drv(0, IDLE, a[0], 1'b0, 3'd2);
      drv(1, IDLE, a[1], 1'b0, 3'd2);
      settle;
      for (int i = 0; i < 2; i++) begin
         total++; if (!pv[i] || bus.m_hready[i] !== 1'b1 || bus.m_hrdata[32*i +: 32] !== pe[i]) begin bad++; $display("FAIL cont_drain m%0d hready=%0b got=%0h exp=%0h", i, bus.m_hready[i], bus.m_hrdata[32*i +: 32], pe[i]); end
      end
      tick;
   endtask

   task automatic test_hold;
      drv(0, NONSEQ, 32'h20, 1'b0, 3'd2);
      settle;
      total++; if (bus.s_haddr !== 32'h20) begin bad++; $display("FAIL hold_first_addr got=%0h exp=20", bus.s_haddr); end
      tick;
      drv(0, NONSEQ, 32'h24, 1'b0, 3'd2);
      drv(1, NONSEQ, 32'h220, 1'b0, 3'd2);
      settle;
      total++; if (bus.m_hready !== 2'b10) begin bad++; $display("FAIL hold_lose got=%0b exp=10", bus.m_hready); end
      total++; if (bus.s_haddr !== 32'h220) begin bad++; $display("FAIL hold_m1_addr got=%0h exp=220", bus.s_haddr); end
      tick;
      drv(1, IDLE, 32'h220, 1'b0, 3'd2);
      settle;
      total++; if (bus.m_hready !== 2'b11) begin bad++; $display("FAIL hold_replay_hready got=%0b exp=11", bus.m_hready); end
      total++; if (bus.m_hrdata[31:0] !== ref_mem[8'h08]) begin bad++; $display("FAIL hold_replay_data got=%0h exp=%0h", bus.m_hrdata[31:0], ref_mem[8'h08]); end
      total++; if (bus.m_hrdata[63:32] !== ref_mem[8'h88]) begin bad++; $display("FAIL hold_m1_data got=%0h exp=%0h", bus.m_hrdata[63:32], ref_mem[8'h88]); end
      total++; if (bus.s_haddr !== 32'h24) begin bad++; $display("FAIL hold_m0_addr got=%0h exp=24", bus.s_haddr); end
      tick;
      drv(0, IDLE, 32'h24, 1'b0, 3'd2);
      settle;
      total++; if (bus.m_hrdata[31:0] !== ref_mem[8'h09]) begin bad++; $display("FAIL hold_next_data got=%0h exp=%0h", bus.m_hrdata[31:0], ref_mem[8'h09]); end
      tick;
   endtask

   task automatic test_wait_states;
      drv(1, NONSEQ, 32'h40, 1'b1, 3'd2);
      settle;
      total++; if (bus.m_hready[1] !== 1'b1) begin bad++; $display("FAIL ws_wr_accept got=%0b exp=1", bus.m_hready[1]); end
      tick;
      drv(1, IDLE, 32'h40, 1'b1, 3'd2);
      bus.m_hwdata[63:32] = 32'hDEADBEEF;
      drv(0, NONSEQ, 32'h80, 1'b0, 3'd2);
      stall = 1'b1;
      for (int c = 0; c < 2; c++) begin
         settle;
         total++; if (bus.s_hwdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ws_hwdata c=%0d got=%0h exp=deadbeef", c, bus.s_hwdata); end
         total++; if (bus.m_hready !== 2'b00) begin bad++; $display("FAIL ws_hready c=%0d got=%0b exp=00", c, bus.m_hready); end
         total++; if (bus.s_htrans !== IDLE) begin bad++; $display("FAIL ws_htrans c=%0d got=%0h exp=0", c, bus.s_htrans); end
         total++; if (bus.s_haddr !== 32'h80) begin bad++; $display("FAIL ws_haddr c=%0d got=%0h exp=80", c, bus.s_haddr); end
         tick;
      end
      stall = 1'b0;
      settle;
      total++; if (bus.m_hready !== 2'b11) begin bad++; $display("FAIL ws_release_hready got=%0b exp=11", bus.m_hready); end
      total++; if (bus.s_htrans !== NONSEQ || bus.s_haddr !== 32'h80) begin bad++; $display("FAIL ws_m0_grant htrans=%0h haddr=%0h exp=2/80", bus.s_htrans, bus.s_haddr); end
      ref_write(32'h40, 32'hDEADBEEF, 3'd2);
      tick;
      drv(0, IDLE, 32'h80, 1'b0, 3'd2);
      settle;
      total++; if (bus.m_hrdata[31:0] !== ref_mem[8'h20]) begin bad++; $display("FAIL ws_m0_rdata got=%0h exp=%0h", bus.m_hrdata[31:0], ref_mem[8'h20]); end
      tick;
   endtask

   task automatic test_byte_write;
      drv(1, NONSEQ, 32'h43, 1'b1, 3'd0);
      settle;
      total++; if (bus.m_hready[1] !== 1'b1) begin bad++; $display("FAIL byte_accept got=%0b exp=1", bus.m_hready[1]); end
      tick;
      drv(1, IDLE, 32'h43, 1'b1, 3'd0);
      bus.m_hwdata[63:32] = 32'hAB00_0000;
      drv(0, NONSEQ, 32'h40, 1'b0, 3'd2);
      ref_write(32'h43, 32'hAB00_0000, 3'd0);
      tick;
      drv(0, IDLE, 32'h40, 1'b0, 3'd2);
      settle;
      total++; if (bus.m_hrdata[31:0] !== 32'hABADBEEF) begin bad++; $display("FAIL byte_rdata got=%0h exp=abadbeef", bus.m_hrdata[31:0]); end
      tick;
   endtask

   task automatic test_reset_mid_hold;
      drv(1, NONSEQ, 32'h210, 1'b0, 3'd2);
      settle;
      total++; if (bus.m_hready[1] !== 1'b1) begin bad++; $display("FAIL rmh_m1_first got=%0b exp=1", bus.m_hready[1]); end
      tick;
      drv(0, NONSEQ, 32'h30, 1'b0, 3'd2);
      drv(1, NONSEQ, 32'h214, 1'b0, 3'd2);
      settle;
      total++; if (bus.m_hready !== 2'b01) begin bad++; $display("FAIL rmh_m1_loses got=%0b exp=01", bus.m_hready); end
      tick;
      settle;
      total++; if (bus.m_hrdata[63:32] !== ref_mem[8'h84]) begin bad++; $display("FAIL rmh_hold_data got=%0h exp=%0h", bus.m_hrdata[63:32], ref_mem[8'h84]); end
      hresetn = 1'b0;
      settle;
      total++; if (bus.s_htrans !== IDLE) begin bad++; $display("FAIL rmh_htrans got=%0h exp=0", bus.s_htrans); end
      total++; if (bus.m_hready !== 2'b11) begin bad++; $display("FAIL rmh_hready got=%0b exp=11", bus.m_hready); end
      total++; if (bus.m_hresp !== 2'b00) begin bad++; $display("FAIL rmh_hresp got=%0b exp=00", bus.m_hresp); end
      total++; if (bus.m_hrdata[63:32] !== bus.s_hrdata) begin bad++; $display("FAIL rmh_hold_cleared got=%0h exp=%0h", bus.m_hrdata[63:32], bus.s_hrdata); end
      tick;
      hresetn = 1'b1;
      settle;
      total++; if (bus.m_hready !== 2'b01 || bus.s_haddr !== 32'h30) begin bad++; $display("FAIL rmh_first_win hready=%0b haddr=%0h exp=01/30", bus.m_hready, bus.s_haddr); end
      tick;
      drv(0, IDLE, 32'h30, 1'b0, 3'd2);
      drv(1, IDLE, 32'h214, 1'b0, 3'd2);
      tick;
   endtask

   task automatic test_random;
      logic        cur_v  [2];
      logic        cur_w  [2];
      logic [31:0] cur_a  [2];
      logic [31:0] cur_wd [2];
      logic [2:0]  cur_sz [2];
      logic        rd_p   [2];
      logic [31:0] rd_exp [2];
      logic [31:0] dp_wd  [2];
      int          waitc  [2];
      int          last_win;
      logic [7:0]  idx;
      for (int i = 0; i < 2; i++) begin
         cur_v[i] = 1'b0; cur_w[i] = 1'b0; cur_a[i] = 32'h0; cur_wd[i] = 32'h0;
         cur_sz[i] = 3'd2; rd_p[i] = 1'b0; rd_exp[i] = 32'h0; dp_wd[i] = 32'h0; waitc[i] = 0;
      end
      do_reset;
      last_win = 1;
      for (int c = 0; c < 1540; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!cur_v[i] && c < 1500 && ($urandom % 4) != 0) begin
               cur_v[i]  = 1'b1;
               cur_w[i]  = 1'($urandom % 2);
               cur_sz[i] = 3'($urandom_range(2, 0));
               idx       = 8'($urandom_range(127, 0)) + ((i == 1) ? 8'd128 : 8'd0);
               cur_a[i]  = {22'd0, idx, 2'b00};
               if (cur_sz[i] == 3'd0) cur_a[i][1:0] = 2'($urandom % 4);
               if (cur_sz[i] == 3'd1) cur_a[i][1]   = 1'($urandom % 2);
               cur_wd[i] = $urandom;
            end
            drv(i, cur_v[i] ? NONSEQ : IDLE, cur_a[i], cur_w[i], cur_sz[i]);
            bus.m_hwdata[32*i +: 32] = dp_wd[i];
         end
         stall = (c < 1500) && (($urandom % 5) == 0);
         settle;
         total++; if (bus.m_hresp !== 2'b00) begin bad++; $display("FAIL rnd_hresp c=%0d got=%0b exp=00", c, bus.m_hresp); end
         if (!stall && cur_v[0] && cur_v[1]) begin
            total++; if (bus.m_hready !== ((last_win == 1) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL rnd_rr c=%0d got=%0b exp_winner=m%0d", c, bus.m_hready, 1 - last_win); end
         end
         for (int i = 0; i < 2; i++) begin
            if (bus.m_hready[i]) begin
               if (rd_p[i]) begin
                  total++; if (bus.m_hrdata[32*i +: 32] !== rd_exp[i]) begin bad++; $display("FAIL rnd_rdata m%0d c=%0d got=%0h exp=%0h", i, c, bus.m_hrdata[32*i +: 32], rd_exp[i]); end
                  rd_p[i] = 1'b0;
               end
               if (cur_v[i]) begin
                  total++; if (waitc[i] > 30) begin bad++; $display("FAIL rnd_wait m%0d c=%0d got=%0d exp<=30", i, c, waitc[i]); end
                  if (cur_w[i]) begin
                     ref_write(cur_a[i], cur_wd[i], cur_sz[i]);
                     dp_wd[i] = cur_wd[i];
                  end else begin
                     rd_p[i]   = 1'b1;
                     rd_exp[i] = ref_mem[cur_a[i][9:2]];
                  end
                  last_win = i;
                  cur_v[i] = 1'b0;
                  waitc[i] = 0;
               end
            end else if (cur_v[i]) begin
               waitc[i]++;
            end
         end
         tick;
      end
      for (int i = 0; i < 2; i++) begin
         total++; if (rd_p[i] || cur_v[i]) begin bad++; $display("FAIL rnd_drain m%0d pending_rd=%0b pending_req=%0b exp=0/0", i, rd_p[i], cur_v[i]); end
      end
   endtask

   initial begin
      bus.m_haddr     = '0;
      bus.m_hwrite    = '0;
      bus.m_hsize     = 6'b010_010;
      bus.m_hburst    = '0;
      bus.m_hmastlock = '0;
      bus.m_hprot     = '0;
      bus.m_htrans    = '0;
      bus.m_hwdata    = '0;
      ld_en = 1'b1;
      for (int k = 0; k < 256; k++) begin
         ld_idx     = 8'(k);
         ld_data    = $urandom;
         ref_mem[k] = ld_data;
         @(posedge hclk);
         #1;
      end
      ld_en = 1'b0;
      test_reset;
      test_single_read;
      test_contention;
      test_hold;
      test_wait_states;
      test_byte_write;
      test_reset_mid_hold;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
